// File: rtl/imaginative_guy_are_you.sv
// Four-lane 4-bit register file with load/rotate/hold and a registered
// reduction output (sum, max, min, lane-0 pass-through).

module imaginative_guy_are_you_lane #(
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             rot_en,
  input  logic [VEC_W-1:0] ld_data,
  input  logic [VEC_W-1:0] rot_data,
  output logic [VEC_W-1:0] r_q
);
  logic [VEC_W-1:0] r_d;

  always_comb begin
    r_d = r_q;
    if (ld_en)       r_d = ld_data;
    else if (rot_en) r_d = rot_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= r_d;
  end
endmodule

module imaginative_guy_are_you (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [1:0] ctrl1,
  input  logic [1:0] ctrl2,
  output logic [3:0] out
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_ROT  = 2'b01,
    CMD_COMP = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    OP_SUM  = 2'b00,
    OP_MAX  = 2'b01,
    OP_MIN  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  cmd_e cmd;
  op_e  op;
  logic [NUM_LANES-1:0][VEC_W-1:0] ld_vec;
  logic [NUM_LANES-1:0][VEC_W-1:0] r_vec;
  logic [NUM_LANES-1:0][VEC_W-1:0] rot_vec;

  assign cmd    = cmd_e'(ctrl2);
  assign op     = op_e'(ctrl1);
  assign ld_vec = {in3, in2, in1, in0};

  // Rotation moves each lane down by one; lane 0 wraps to the top.
  assign rot_vec = {r_vec[0], r_vec[NUM_LANES-1:1]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    imaginative_guy_are_you_lane #(.VEC_W(VEC_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld_en    (cmd == CMD_LOAD),
      .rot_en   (cmd == CMD_ROT),
      .ld_data  (ld_vec[i]),
      .rot_data (rot_vec[i]),
      .r_q      (r_vec[i])
    );
  end

  logic [5:0]       sum_full;
  logic [VEC_W-1:0] max_v;
  logic [VEC_W-1:0] min_v;
  logic [VEC_W-1:0] red;
  logic [VEC_W-1:0] out_d;
  logic [VEC_W-1:0] out_q;

  always_comb begin
    sum_full = '0;
    max_v    = r_vec[0];
    min_v    = r_vec[0];
    for (int i = 0; i < NUM_LANES; i++) begin
      sum_full = sum_full + 6'(r_vec[i]);
      if (r_vec[i] > max_v) max_v = r_vec[i];
      if (r_vec[i] < min_v) min_v = r_vec[i];
    end
  end

  always_comb begin
    red = r_vec[0];
    case (op)
      OP_SUM:  red = sum_full[VEC_W-1:0];
      OP_MAX:  red = max_v;
      OP_MIN:  red = min_v;
      OP_PASS: red = r_vec[0];
      default: red = r_vec[0];
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (cmd == CMD_COMP) out_d = red;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;
endmodule

// File: tb/tb_imaginative_guy_are_you.sv
// Bench for imaginative_guy_are_you: reference model checked every cycle
// plus directed literal expectations.

module tb_imaginative_guy_are_you;
  logic       clk;
  logic       rst;
  logic [3:0] in0, in1, in2, in3;
  logic [1:0] ctrl1, ctrl2;
  logic [3:0] out;

  int checks;
  int failures;

  int m_r[4];
  int m_out;

  imaginative_guy_are_you dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .ctrl1(ctrl1), .ctrl2(ctrl2),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int f_red(int op, int r[4]);
    int s, mx, mn;
    s = r[0] + r[1] + r[2] + r[3];
    mx = r[0]; mn = r[0];
    foreach (r[i]) begin
      if (r[i] > mx) mx = r[i];
      if (r[i] < mn) mn = r[i];
    end
    case (op)
      0: return s % 16;
      1: return mx;
      2: return mn;
      default: return r[0];
    endcase
  endfunction

  // Reference model: state as plain integers updated by command meaning.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_r[i]) m_r[i] = 0;
      m_out = 0;
    end else begin
      int t[4];
      t = m_r;
      case (ctrl2)
        2'b01: begin m_r[0] = t[1]; m_r[1] = t[2]; m_r[2] = t[3]; m_r[3] = t[0]; end
        2'b10: m_out = f_red(int'(ctrl1), t);
        2'b11: begin m_r[0] = in0; m_r[1] = in1; m_r[2] = in2; m_r[3] = in3; end
        default: ;
      endcase
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst) check("model_cmp", int'(out), m_out);
  end

  task automatic cmd(input logic [1:0] c2, input logic [1:0] c1,
                     input int a, input int b, input int c, input int d);
    @(negedge clk);
    ctrl2 = c2; ctrl1 = c1;
    in0 = 4'(a); in1 = 4'(b); in2 = 4'(c); in3 = 4'(d);
    @(posedge clk);
    #3;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    in0 = 4'($urandom); in1 = 4'($urandom); in2 = 4'($urandom); in3 = 4'($urandom);
    ctrl1 = 2'($urandom); ctrl2 = 2'($urandom);
    #1;
    check("reset_out", int'(out), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    cmd(2'b10, 2'b00, 5, 5, 5, 5); check("post_reset_sum", int'(out), 0);

    cmd(2'b11, 2'b00, 1, 2, 3, 4);
    cmd(2'b10, 2'b00, 0, 0, 0, 0); check("sum_1234", int'(out), 10);
    cmd(2'b10, 2'b01, 0, 0, 0, 0); check("max_1234", int'(out), 4);
    cmd(2'b10, 2'b10, 0, 0, 0, 0); check("min_1234", int'(out), 1);
    cmd(2'b10, 2'b11, 0, 0, 0, 0); check("pass_1234", int'(out), 1);

    cmd(2'b10, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cmd(2'b00, 2'(i), i + 3, i * 2, 15 - i, i);
      check("hold", int'(out), 10);
    end

    cmd(2'b11, 2'b00, 15, 15, 15, 15);
    cmd(2'b10, 2'b00, 0, 0, 0, 0); check("sum_ovf", int'(out), 12);
    cmd(2'b10, 2'b01, 0, 0, 0, 0); check("max_15", int'(out), 15);
    cmd(2'b10, 2'b10, 0, 0, 0, 0); check("min_15", int'(out), 15);

    cmd(2'b11, 2'b00, 1, 2, 3, 4);
    cmd(2'b01, 2'b00, 0, 0, 0, 0); check("rot_out_unchanged", int'(out), 15);
    cmd(2'b10, 2'b11, 0, 0, 0, 0); check("rot1_pass", int'(out), 2);
    for (int i = 0; i < 3; i++) begin
      cmd(2'b01, 2'b11, 0, 0, 0, 0);
      check("rot_hold_out", int'(out), 2);
    end
    cmd(2'b10, 2'b11, 0, 0, 0, 0); check("rot4_wrap", int'(out), 1);

    cmd(2'b11, 2'b00, 9, 0, 0, 0);
    cmd(2'b10, 2'b00, 0, 0, 0, 0); check("sum_9000", int'(out), 9);
    cmd(2'b10, 2'b01, 0, 0, 0, 0); check("max_9000", int'(out), 9);
    cmd(2'b10, 2'b10, 0, 0, 0, 0); check("min_9000", int'(out), 0);

    cmd(2'b11, 2'b00, 1, 2, 3, 4);
    cmd(2'b10, 2'b00, 15, 15, 15, 15); check("comp_ignores_in", int'(out), 10);
    cmd(2'b10, 2'b01, 0, 0, 0, 0); check("comp_ignores_in_max", int'(out), 4);

    cmd(2'b11, 2'b00, 7, 7, 7, 7);
    cmd(2'b10, 2'b00, 0, 0, 0, 0); check("sum_7777", int'(out), 12);
    @(negedge clk);
    ctrl2 = 2'b00;
    #1 rst = 1'b1;
    #1 check("async_rst_out", int'(out), 0);
    #1 rst = 1'b0;
    cmd(2'b10, 2'b01, 0, 0, 0, 0); check("max_after_rst", int'(out), 0);
    cmd(2'b10, 2'b11, 0, 0, 0, 0); check("pass_after_rst", int'(out), 0);

    for (int i = 0; i < 300; i++)
      cmd(2'($urandom), 2'($urandom), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)));

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imaginative_guy_are_you.md
Name: imaginative_guy_are_you

Overview:
- Small 4-lane, 4-bit register-file datapath with a command interface.
- A 2-bit command (ctrl2) loads, rotates, holds or reduces four internal 4-bit registers.
- A 2-bit operation select (ctrl1) picks the reduction: sum, max, min, or lane-0 pass-through.
- The result is presented on a registered 4-bit output. Sits as a leaf compute block driven by a controller that alternates load and compute commands.

Parameters:
- none. All widths are fixed: 4-bit data, 2-bit controls.

Ports:
- clk    input   1   system clock; all state updates on rising edge.
- rst    input   1   asynchronous, active-high reset; clears all state immediately.
- in0    input   4   load data for register r0.
- in1    input   4   load data for register r1.
- in2    input   4   load data for register r2.
- in3    input   4   load data for register r3.
- ctrl1  input   2   operation select for the compute command.
- ctrl2  input   2   command: 00 hold, 01 rotate, 10 compute, 11 load.
- out    output  4   registered result.

Behaviour:
- State: four 4-bit registers r0..r3 plus the 4-bit out register.
- Reset: while rst=1, r0..r3=0 and out=0, independent of clk. Reset asserted mid-operation discards all state at once. The first command is acted on at the first rising edge after rst deasserts.
- Each rising edge (rst=0) decodes ctrl2, sampled together with ctrl1 and in0..in3 at that edge:
  - 00 hold: r0..r3 and out unchanged.
  - 01 rotate: r0<=r1, r1<=r2, r2<=r3, r3<=r0. out unchanged.
  - 10 compute: out<=f(ctrl1) using pre-edge r0..r3. Registers unchanged.
  - 11 load: ri<=ini for i=0..3. out unchanged.
- f(ctrl1), all arithmetic unsigned:
  - 00: (r0+r1+r2+r3) mod 16. Compute the full sum at 6 bits, then truncate to the low 4 bits.
  - 01: max(r0,r1,r2,r3).
  - 10: min(r0,r1,r2,r3).
  - 11: r0 (pass-through, exposes rotation state).
- Latency:
  - Load at edge N followed by compute at edge N+1: out reflects the loaded data after edge N+1 (one cycle load-to-compute).
  - Compute-to-out is one edge. out is a pure register output with no combinational path from any input.
- Compute with ctrl2=10 in the same cycle as new in0..in3 data uses the old register contents; in* are ignored.
- Ties in max/min return the common value. An all-equal register set gives that value for both max and min.
- Undefined/X inputs need no special handling; ctrl values are always fully decoded.

Test Plan:
- Reset: rst=1 with random inputs -> out=0 immediately (before any clk edge). Deassert, compute with ctrl1=00 -> out=0.
- Load in0..3=1,2,3,4 (ctrl2=11), then compute:
  - ctrl1=00 -> out=10.
  - ctrl1=01 -> out=4.
  - ctrl1=10 -> out=1.
  - ctrl1=11 -> out=1.
- Overflow: load 15,15,15,15, compute ctrl1=00 -> out=12 (60 mod 16). Then ctrl1=01 -> 15 and ctrl1=10 -> 15.
- Rotate: load 1,2,3,4. Rotate once and compute ctrl1=11 -> out=2. Rotate three more times and compute -> out=1 (wrap-around). out is unchanged during the rotate cycles.
- Hold/ordering:
  - After out=10, apply ctrl2=00 for 5 cycles with changing in* -> out stays 10.
  - Load 9,0,0,0 then compute ctrl1=00 -> out=9.
  - Compute in the same cycle as new in* -> result uses the old registers.
- Reset mid-run: after load 7,7,7,7 and compute out=12, pulse rst asynchronously between edges -> out=0 at once. Compute ctrl1=01 after release -> out=0.
